dds_sweep_ctrl: RTL and testbench

Linear frequency-sweep sequencer driving the 24-bit `fre` tuning word (Hz) of the SINCOS quadrature DDS core. It holds a latched sweep configuration (start, stop, step, dwell, mode) and steps `fre` from start to stop, holding each point for a programmable number of `clk_100M` cycles. It runs single-shot or continuous, reports busy/done/error status and accepts abort. It sits between the control/register logic and the DDS phase accumulator.

---
 rtl/dds_sweep_ctrl.sv | 144 ++++++++++++++
 tb/tb_dds_sweep_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_sweep_ctrl.sv
// Linear frequency-sweep sequencer for the SINCOS DDS tuning word.
// Holds a latched sweep config and walks fre from start to stop with a per-point dwell.
module dds_sweep_ctrl #(
  parameter int unsigned DWELL_W = 24
) (
  input  logic               clk_100M,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [23:0]        cfg_start,
  input  logic [23:0]        cfg_stop,
  input  logic [23:0]        cfg_step,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic               cfg_mode,
  input  logic               go,
  input  logic               abort,
  output logic [23:0]        fre,
  output logic               fre_upd,
  output logic               busy,
  output logic               done,
  output logic               err
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e state_q, state_d;

  logic [23:0]        start_q, start_d;
  logic [23:0]        stop_q, stop_d;
  logic [23:0]        step_q, step_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               mode_q, mode_d;

  logic [23:0]        fre_q, fre_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               upd_q, upd_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic               cap;
  logic               eff_valid;
  logic [24:0]        nxt;

  // Config written this cycle is visible to a same-cycle go.
  assign cap       = cfg_valid && (state_q == StIdle);
  assign eff_valid = (start_d != 24'd0) && (step_d != 24'd0) && (start_d <= stop_d);
  assign nxt       = {1'b0, fre_q} + {1'b0, step_q};

  always_comb begin
    start_d = start_q;
    stop_d  = stop_q;
    step_d  = step_q;
    dwell_d = dwell_q;
    mode_d  = mode_q;
    if (cap) begin
      start_d = cfg_start;
      stop_d  = cfg_stop;
      step_d  = cfg_step;
      dwell_d = cfg_dwell;
      mode_d  = cfg_mode;
    end
  end

  always_comb begin
    state_d = state_q;
    fre_d   = fre_q;
    cnt_d   = cnt_q;
    upd_d   = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    if (abort) begin
      state_d = StIdle;
      fre_d   = 24'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (go) begin
            if (eff_valid) begin
              fre_d   = start_d;
              cnt_d   = dwell_d;
              upd_d   = 1'b1;
              state_d = StRun;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        StRun: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - {{(DWELL_W-1){1'b0}}, 1'b1};
          end else if (nxt <= {1'b0, stop_q}) begin
            fre_d = nxt[23:0];
            cnt_d = dwell_q;
            upd_d = 1'b1;
          end else if (mode_q) begin
            fre_d = start_q;
            cnt_d = dwell_q;
            upd_d = 1'b1;
          end else begin
            done_d  = 1'b1;
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_100M or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      start_q <= '0;
      stop_q  <= '0;
      step_q  <= '0;
      dwell_q <= '0;
      mode_q  <= 1'b0;
      fre_q   <= '0;
      cnt_q   <= '0;
      upd_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      stop_q  <= stop_d;
      step_q  <= step_d;
      dwell_q <= dwell_d;
      mode_q  <= mode_d;
      fre_q   <= fre_d;
      cnt_q   <= cnt_d;
      upd_q   <= upd_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign cfg_ready = (state_q == StIdle);
  assign busy      = (state_q == StRun);
  assign fre       = fre_q;
  assign fre_upd   = upd_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed bench for dds_sweep_ctrl: table of single-shot/invalid configs plus
// hand-written reset, continuous/abort and handshake sequences.
module tb_dds_sweep_ctrl;

  logic        clk_100M = 1'b0;
  logic        rst;
  logic        cfg_valid, cfg_ready;
  logic [23:0] cfg_start, cfg_stop, cfg_step;
  logic [23:0] cfg_dwell;
  logic        cfg_mode, go, abort;
  logic [23:0] fre;
  logic        fre_upd, busy, done, err;

  int total = 0;
  int bad   = 0;
  logic [23:0] hold_fre;

  always #5 clk_100M = ~clk_100M;

  dds_sweep_ctrl #(.DWELL_W(24)) dut (
    .clk_100M  (clk_100M),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_start (cfg_start),
    .cfg_stop  (cfg_stop),
    .cfg_step  (cfg_step),
    .cfg_dwell (cfg_dwell),
    .cfg_mode  (cfg_mode),
    .go        (go),
    .abort     (abort),
    .fre       (fre),
    .fre_upd   (fre_upd),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  typedef struct {
    string       name;
    logic [23:0] start;
    logic [23:0] stop;
    logic [23:0] step;
    logic [23:0] dwell;
    bit          is_err;
    int          n;
    logic [23:0] last;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_100M);
    #1;
  endtask

  task automatic set_cfg(input logic [23:0] s, input logic [23:0] e, input logic [23:0] st,
                         input logic [23:0] d, input logic m);
    cfg_start = s;
    cfg_stop  = e;
    cfg_step  = st;
    cfg_dwell = d;
    cfg_mode  = m;
  endtask

  task automatic write_cfg(input logic [23:0] s, input logic [23:0] e, input logic [23:0] st,
                           input logic [23:0] d, input logic m);
    set_cfg(s, e, st, d, m);
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic pulse_go();
    go = 1'b1;
    tick();
    go = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  // Called right after the go edge; walks the whole single sweep and the done cycle.
  task automatic check_single(input string nm, input logic [23:0] s, input logic [23:0] st,
                              input int d, input int n, input logic [23:0] last);
    logic [31:0] exp_fre;
    for (int k = 0; k < n * (d + 1); k++) begin
      exp_fre = 32'(s) + 32'(k / (d + 1)) * 32'(st);
      chk({nm, "_fre"}, 32'(fre), exp_fre);
      chk({nm, "_upd"}, 32'(fre_upd), 32'((k % (d + 1)) == 0));
      chk({nm, "_busy"}, 32'(busy), 32'd1);
      chk({nm, "_done_early"}, 32'(done), 32'd0);
      tick();
    end
    chk({nm, "_done"}, 32'(done), 32'd1);
    chk({nm, "_busy_end"}, 32'(busy), 32'd0);
    chk({nm, "_ready_end"}, 32'(cfg_ready), 32'd1);
    chk({nm, "_last"}, 32'(fre), 32'(last));
    tick();
    chk({nm, "_done_clr"}, 32'(done), 32'd0);
    chk({nm, "_hold"}, 32'(fre), 32'(last));
  endtask

  initial begin
    int cont_exp[12];
    bit reached;

    vecs[0] = '{"single",   24'd1000,     24'd1300,     24'd100, 24'd2, 1'b0, 4, 24'd1300};
    vecs[1] = '{"nonalign", 24'd10,       24'd35,       24'd10,  24'd0, 1'b0, 3, 24'd30};
    vecs[2] = '{"ovf",      24'd16777200, 24'd16777215, 24'd10,  24'd1, 1'b0, 2, 24'd16777210};
    vecs[3] = '{"one_pt",   24'd7,        24'd7,        24'd3,   24'd1, 1'b0, 1, 24'd7};
    vecs[4] = '{"step0",    24'd100,      24'd200,      24'd0,   24'd0, 1'b1, 0, 24'd0};
    vecs[5] = '{"rev",      24'd500,      24'd400,      24'd10,  24'd0, 1'b1, 0, 24'd0};
    cont_exp = '{5, 5, 10, 10, 15, 15, 5, 5, 10, 10, 15, 15};

    rst = 1'b1;
    cfg_valid = 1'b0;
    go = 1'b0;
    abort = 1'b0;
    set_cfg(24'd0, 24'd0, 24'd0, 24'd0, 1'b0);
    repeat (2) @(posedge clk_100M);
    #1;
    rst = 1'b0;

    chk("rst_fre", 32'(fre), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(cfg_ready), 32'd1);
    chk("rst_upd", 32'(fre_upd), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);

    // Asynchronous reset in the middle of a sweep.
    write_cfg(24'd1000, 24'd5000, 24'd1000, 24'd3, 1'b0);
    pulse_go();
    reached = 1'b0;
    for (int i = 0; i < 40 && !reached; i++) begin
      if (fre == 24'd3000) reached = 1'b1;
      else tick();
    end
    chk("reach_3000", 32'(reached), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_fre", 32'(fre), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_ready", 32'(cfg_ready), 32'd1);
    tick();
    rst = 1'b0;
    pulse_go();
    chk("zero_cfg_err", 32'(err), 32'd1);
    chk("zero_cfg_busy", 32'(busy), 32'd0);
    chk("zero_cfg_fre", 32'(fre), 32'd0);
    tick();
    chk("zero_cfg_err_clr", 32'(err), 32'd0);
    hold_fre = 24'd0;

    for (int v = 0; v < 6; v++) begin
      write_cfg(vecs[v].start, vecs[v].stop, vecs[v].step, vecs[v].dwell, 1'b0);
      pulse_go();
      if (vecs[v].is_err) begin
        chk({vecs[v].name, "_err"}, 32'(err), 32'd1);
        chk({vecs[v].name, "_busy"}, 32'(busy), 32'd0);
        chk({vecs[v].name, "_upd"}, 32'(fre_upd), 32'd0);
        chk({vecs[v].name, "_fre"}, 32'(fre), 32'(hold_fre));
        tick();
        chk({vecs[v].name, "_err_clr"}, 32'(err), 32'd0);
      end else begin
        check_single(vecs[v].name, vecs[v].start, vecs[v].step, int'(vecs[v].dwell),
                     vecs[v].n, vecs[v].last);
        hold_fre = vecs[v].last;
      end
    end

    // Continuous mode, then abort during the second 10.
    write_cfg(24'd5, 24'd15, 24'd5, 24'd1, 1'b1);
    pulse_go();
    for (int k = 0; k < 12; k++) begin
      chk("cont_fre", 32'(fre), 32'(cont_exp[k]));
      chk("cont_upd", 32'(fre_upd), 32'((k % 2) == 0));
      chk("cont_done", 32'(done), 32'd0);
      chk("cont_busy", 32'(busy), 32'd1);
      tick();
    end
    tick();
    tick();
    chk("cont_first10", 32'(fre), 32'd10);
    tick();
    chk("cont_second10", 32'(fre), 32'd10);
    chk("cont_second10_upd", 32'(fre_upd), 32'd0);
    pulse_abort();
    chk("abort_fre", 32'(fre), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_upd", 32'(fre_upd), 32'd0);
    pulse_go();
    chk("post_abort_go_fre", 32'(fre), 32'd5);
    chk("post_abort_go_busy", 32'(busy), 32'd1);
    abort = 1'b1;
    go = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_go_run_busy", 32'(busy), 32'd0);
    tick();
    go = 1'b0;
    chk("go_after_abort_busy", 32'(busy), 32'd1);
    chk("go_after_abort_fre", 32'(fre), 32'd5);
    pulse_abort();
    abort = 1'b1;
    go = 1'b1;
    tick();
    abort = 1'b0;
    go = 1'b0;
    chk("abort_over_go_busy", 32'(busy), 32'd0);
    chk("abort_over_go_fre", 32'(fre), 32'd0);

    // cfg_valid during RUN must not disturb the sweep or the latched config.
    write_cfg(24'd100, 24'd300, 24'd100, 24'd0, 1'b0);
    pulse_go();
    set_cfg(24'd7, 24'd9000, 24'd1, 24'd5, 1'b1);
    cfg_valid = 1'b1;
    chk("run_ready", 32'(cfg_ready), 32'd0);
    chk("run_cfg_fre0", 32'(fre), 32'd100);
    tick();
    cfg_valid = 1'b0;
    chk("run_cfg_fre1", 32'(fre), 32'd200);
    tick();
    chk("run_cfg_fre2", 32'(fre), 32'd300);
    tick();
    chk("run_cfg_done", 32'(done), 32'd1);
    pulse_go();
    chk("run_cfg_kept_start", 32'(fre), 32'd100);
    pulse_abort();

    // cfg_valid and go together in IDLE use the new values.
    set_cfg(24'd40, 24'd60, 24'd20, 24'd0, 1'b0);
    cfg_valid = 1'b1;
    go = 1'b1;
    tick();
    cfg_valid = 1'b0;
    go = 1'b0;
    check_single("cfg_go", 24'd40, 24'd20, 0, 2, 24'd60);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
